id_ex_stage: RTL

Decode-to-execute pipeline stage sitting directly in front of the 32x64-bit register file. It drives the register file read addresses from the decoded instruction and resolves operands with forwarding from EX and MEM. It detects load-use hazards, stalls upstream and inserts bubbles, and registers everything into the ID/EX pipeline register consumed by the ALU.

---
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bundle: decoded instruction, register file, forwarding sources, ID/EX outputs
interface id_ex_stage_if;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_wb_en;
    logic        id_is_load;
    logic        id_is_store;
    logic [15:0] id_imm;

    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [63:0] rf_rdata1;
    logic [63:0] rf_rdata2;

    logic [63:0] ex_alu_result;
    logic        mem_valid;
    logic        mem_wb_en;
    logic [4:0]  mem_rd;
    logic [63:0] mem_result;
    logic        flush;

    logic        stall;
    logic        ex_valid;
    logic        ex_wb_en;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [15:0] ex_imm;
    logic [63:0] ex_opa;
    logic [63:0] ex_opb;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
        output id_wb_en, id_is_load, id_is_store, id_imm,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        output ex_alu_result, mem_valid, mem_wb_en, mem_rd, mem_result, flush,
        input  stall, ex_valid, ex_wb_en, ex_is_load, ex_is_store,
        input  ex_op, ex_rd, ex_imm, ex_opa, ex_opb, stall_count
    );

    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
        input  id_wb_en, id_is_load, id_is_store, id_imm,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        input  ex_alu_result, mem_valid, mem_wb_en, mem_rd, mem_result, flush,
        output stall, ex_valid, ex_wb_en, ex_is_load, ex_is_store,
        output ex_op, ex_rd, ex_imm, ex_opa, ex_opb, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute stage: operand forwarding, load-use stall, ID/EX pipeline register
module id_ex_stage (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    logic        r_ex_valid;
    logic        r_ex_wb_en;
    logic        r_ex_is_load;
    logic        r_ex_is_store;
    logic [5:0]  r_ex_op;
    logic [4:0]  r_ex_rd;
    logic [15:0] r_ex_imm;
    logic [63:0] r_ex_opa;
    logic [63:0] r_ex_opb;
    logic [15:0] r_stall_count;

    logic        w_ex_fwd_ok;
    logic        w_mem_fwd_ok;
    logic [63:0] w_opa;
    logic [63:0] w_opb;
    logic        w_dep_rs1;
    logic        w_dep_rs2;
    logic        w_hz;
    logic        w_stall;
    logic        w_cnt_sat;

    assign bus.rf_raddr1 = bus.id_rs1;
    assign bus.rf_raddr2 = bus.id_rs2;

    // A load in EX has no data yet, so only non-load EX results are forwarded
    assign w_ex_fwd_ok  = r_ex_valid && r_ex_wb_en && !r_ex_is_load;
    assign w_mem_fwd_ok = bus.mem_valid && bus.mem_wb_en;

    function automatic logic [63:0] resolve_operand(
        input logic [4:0]  src,
        input logic [63:0] rf_data,
        input logic        ex_ok,
        input logic [4:0]  ex_rd,
        input logic [63:0] ex_data,
        input logic        mem_ok,
        input logic [4:0]  mem_rd,
        input logic [63:0] mem_data
    );
        logic [63:0] result;
        // r0 is forced here: the RF write bypass could otherwise leak write data for address 0
        if (src == 5'd0) begin
            result = 64'h0;
        end else if (ex_ok && (ex_rd == src)) begin
            result = ex_data;
        end else if (mem_ok && (mem_rd == src)) begin
            result = mem_data;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    always_comb begin
        w_opa = resolve_operand(bus.id_rs1, bus.rf_rdata1, w_ex_fwd_ok, r_ex_rd,
                                bus.ex_alu_result, w_mem_fwd_ok, bus.mem_rd, bus.mem_result);
        w_opb = resolve_operand(bus.id_rs2, bus.rf_rdata2, w_ex_fwd_ok, r_ex_rd,
                                bus.ex_alu_result, w_mem_fwd_ok, bus.mem_rd, bus.mem_result);
    end

    assign w_dep_rs1 = bus.id_use_rs1 && (bus.id_rs1 == r_ex_rd);
    assign w_dep_rs2 = bus.id_use_rs2 && (bus.id_rs2 == r_ex_rd);
    assign w_hz      = bus.id_valid && r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0)
                       && (w_dep_rs1 || w_dep_rs2);
    assign w_stall   = w_hz && !bus.flush;
    assign w_cnt_sat = (r_stall_count == 16'hFFFF);

    assign bus.stall = w_stall;

    // On flush or hazard only ex_valid drops; the other fields hold so the bubble is cheap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_wb_en    <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_ex_is_store <= 1'b0;
            r_ex_op       <= 6'd0;
            r_ex_rd       <= 5'd0;
            r_ex_imm      <= 16'd0;
            r_ex_opa      <= 64'd0;
            r_ex_opb      <= 64'd0;
        end else if (bus.flush || w_hz) begin
            r_ex_valid    <= 1'b0;
        end else begin
            r_ex_valid    <= bus.id_valid;
            r_ex_wb_en    <= bus.id_wb_en;
            r_ex_is_load  <= bus.id_is_load;
            r_ex_is_store <= bus.id_is_store;
            r_ex_op       <= bus.id_op;
            r_ex_rd       <= bus.id_rd;
            r_ex_imm      <= bus.id_imm;
            r_ex_opa      <= w_opa;
            r_ex_opb      <= w_opb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_wb_en    = r_ex_wb_en;
    assign bus.ex_is_load  = r_ex_is_load;
    assign bus.ex_is_store = r_ex_is_store;
    assign bus.ex_op       = r_ex_op;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_opa      = r_ex_opa;
    assign bus.ex_opb      = r_ex_opb;
    assign bus.stall_count = r_stall_count;
endmodule
